// File: rtl/axis_rr_packet_arbiter.sv
// rtl/axis_rr_packet_arbiter.sv - whole-packet round-robin arbiter of NUM_PORTS AXI-Stream slaves onto one registered master
module axis_rr_packet_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  output logic                            grant_active,
  output logic [ID_WIDTH-1:0]             grant_idx
);

  typedef enum logic {IDLE, PASS} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic [ID_WIDTH-1:0]   tid_q;

  logic                  out_ready;
  logic                  accept;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  hi_found;
  logic [ID_WIDTH-1:0]   hi_idx;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    hi_found   = 1'b0;
    hi_idx     = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) begin
        pick_found = 1'b1;
        pick_idx   = ID_WIDTH'(i);
        if (i > int'(last_grant_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_WIDTH'(i);
        end
      end
    end
    if (hi_found) begin
      pick_idx = hi_idx;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_ready = ~tvalid_q | m_axis_tready;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    s_axis_tready = '0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = PASS;
        end
      end
      PASS: begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (grant_q == ID_WIDTH'(i)) begin
            s_axis_tready[i] = out_ready;
          end
        end
        accept = sel_valid & out_ready;
        if (accept && sel_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing may be acknowledged while reset is being applied.
    if (axis_areset) begin
      s_axis_tready = '0;
      accept        = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q      <= IDLE;
      grant_q      <= ID_WIDTH'(NUM_PORTS - 1);
      last_grant_q <= ID_WIDTH'(NUM_PORTS - 1);
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tid_q        <= '0;
      tdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      if (accept) begin
        tvalid_q <= 1'b1;
        tlast_q  <= sel_last;
        tid_q    <= grant_q;
        tdata_q  <= sel_data;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;
  assign grant_active  = (state_q == PASS);
  assign grant_idx     = grant_q;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// tb/tb_axis_rr_packet_arbiter.sv - self-checking bench for axis_rr_packet_arbiter
module tb_axis_rr_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    s_tlast;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic            gact;
  logic [IW-1:0]   gidx;

  always #5 clk = ~clk;

  axis_rr_packet_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .axis_aclk(clk), .axis_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .grant_active(gact), .grant_idx(gidx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: granted port (-1 when arbitrating), last winner, output beat.
  int          mb;
  int          mlast;
  bit          mv;
  bit          mlst;
  logic [31:0] md;
  int          mt;

  task automatic model_reset();
    mb = -1; mlast = N - 1; mv = 0; mlst = 0; md = '0; mt = 0;
  endtask

  typedef struct { int tid; logic [31:0] d; bit last; } beat_t;
  beat_t out_q[$];

  task automatic apply(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N*DW-1:0] d,
                       input bit mr, input bit r, output logic [N-1:0] rdy);
    logic [N-1:0] exp_rdy;
    bit acc;
    beat_t b;
    s_tvalid = v; s_tlast = l; s_tdata = d; m_tready = mr; rst = r;
    #1;
    rdy = s_tready;
    exp_rdy = '0;
    if (!r && mb >= 0 && (!mv || mr)) exp_rdy = N'(1 << mb);
    chk("tready", rdy, exp_rdy);
    if (m_tvalid && mr) begin
      b.tid = int'(m_tid); b.d = m_tdata; b.last = m_tlast;
      out_q.push_back(b);
    end
    if (r) begin
      model_reset();
    end else begin
      acc = 0;
      if (mb >= 0) acc = v[mb] && exp_rdy[mb];
      if (acc) begin
        mv = 1; md = d[mb*DW +: DW]; mlst = l[mb]; mt = mb;
      end else if (mr) begin
        mv = 0;
      end
      if (mb < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (mb < 0 && v[(mlast + k) % N]) mb = (mlast + k) % N;
        end
      end else if (acc && l[mb]) begin
        mlast = mb;
        mb = -1;
      end
    end
    @(posedge clk);
    #1;
    chk("m_tvalid", m_tvalid, mv);
    if (mv) begin
      chk("m_tdata", m_tdata, md);
      chk("m_tlast", m_tlast, mlst);
      chk("m_tid", m_tid, mt);
    end
    chk("grant_active", gact, mb >= 0);
    chk("grant_idx", gidx, (mb >= 0) ? mb : mlast);
  endtask

  // Per-port source: data = {port, sequence number}, packets of len beats.
  int seq[N];
  int beat[N];
  int len[N];
  bit en[N];
  bit vld[N];
  bit rand_mode;

  task automatic src_reset();
    for (int p = 0; p < N; p++) begin
      seq[p] = 0; beat[p] = 0; len[p] = 2; en[p] = 0; vld[p] = 0;
    end
    rand_mode = 0;
  endtask

  task automatic bfm(input bit mr, input bit r, output logic [N-1:0] rdy);
    logic [N-1:0] v, l;
    logic [N*DW-1:0] d;
    for (int p = 0; p < N; p++) begin
      if (!rand_mode) vld[p] = en[p];
      v[p] = vld[p];
      l[p] = (beat[p] == len[p] - 1);
      d[p*DW +: DW] = {8'(p), 24'(seq[p])};
    end
    apply(v, l, d, mr, r, rdy);
    for (int p = 0; p < N; p++) begin
      if (v[p] && rdy[p]) begin
        seq[p]++;
        if (l[p]) begin
          beat[p] = 0;
          if (rand_mode) len[p] = $urandom_range(1, 4);
        end else begin
          beat[p]++;
        end
      end
      if (rand_mode && (!v[p] || rdy[p])) vld[p] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic do_reset();
    logic [N-1:0] r;
    bfm(1, 1, r);
    bfm(1, 1, r);
  endtask

  typedef struct {
    logic [N-1:0] v; logic [N-1:0] l; logic [31:0] d;
    logic [N-1:0] e_rdy; logic e_mv; logic [31:0] e_md; logic e_ml; logic [IW-1:0] e_tid; logic e_gact;
  } vec_t;

  vec_t tbl[5];
  int   t5_exp[4] = '{1, 3, 1, 3};
  int   es[N];

  initial begin
    logic [N-1:0] r;
    int lastq[$];
    int cnt;
    logic [N-1:0] e;

    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1; rst = 1'b1;
    model_reset();
    src_reset();

    tbl[0] = '{4'b0100, 4'b0000, 32'hA0, 4'b0000, 1'b0, 32'h0,  1'b0, 3'd0, 1'b1};
    tbl[1] = '{4'b0100, 4'b0000, 32'hA0, 4'b0100, 1'b1, 32'hA0, 1'b0, 3'd2, 1'b1};
    tbl[2] = '{4'b0100, 4'b0000, 32'hA1, 4'b0100, 1'b1, 32'hA1, 1'b0, 3'd2, 1'b1};
    tbl[3] = '{4'b0100, 4'b0100, 32'hA2, 4'b0100, 1'b1, 32'hA2, 1'b1, 3'd2, 1'b0};
    tbl[4] = '{4'b0000, 4'b0000, 32'h0,  4'b0000, 1'b0, 32'h0,  1'b0, 3'd0, 1'b0};

    do_reset();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tid", m_tid, 0);
    chk("rst_gact", gact, 0);
    chk("rst_gidx", gidx, N - 1);

    // Port 2 three-beat packet.
    for (int i = 0; i < 5; i++) begin
      apply(tbl[i].v, tbl[i].l, {N{tbl[i].d}}, 1'b1, 1'b0, r);
      chk($sformatf("t1_rdy_%0d", i), r, tbl[i].e_rdy);
      chk($sformatf("t1_mv_%0d", i), m_tvalid, tbl[i].e_mv);
      chk($sformatf("t1_gact_%0d", i), gact, tbl[i].e_gact);
      if (tbl[i].e_mv) begin
        chk($sformatf("t1_md_%0d", i), m_tdata, tbl[i].e_md);
        chk($sformatf("t1_ml_%0d", i), m_tlast, tbl[i].e_ml);
        chk($sformatf("t1_tid_%0d", i), m_tid, tbl[i].e_tid);
      end
    end

    // All ports request two-beat packets: grant 0,1,2,3,0 with one idle cycle between.
    do_reset(); src_reset();
    for (int p = 0; p < N; p++) en[p] = 1;
    out_q.delete();
    for (int c = 0; c < 16; c++) begin
      bfm(1, 0, r);
      e = (c % 3 == 0) ? '0 : N'(1 << ((c / 3) % N));
      chk($sformatf("t2_rdy_c%0d", c), r, e);
    end
    lastq.delete();
    foreach (out_q[i]) if (out_q[i].last) lastq.push_back(out_q[i].tid);
    chk("t2_npkts", lastq.size(), 5);
    foreach (lastq[i]) chk($sformatf("t2_order_%0d", i), lastq[i], i % N);

    // Downstream stall mid-packet on port 1.
    do_reset(); src_reset();
    en[1] = 1; len[1] = 3; en[2] = 1;
    out_q.delete();
    for (int c = 0; c < 3; c++) bfm(1, 0, r);
    for (int c = 0; c < 5; c++) begin
      bfm(0, 0, r);
      chk("t3_stall_rdy", r, 0);
      chk("t3_stall_data", m_tdata, 32'h0100_0001);
      chk("t3_stall_tid", m_tid, 1);
      chk("t3_stall_last", m_tlast, 0);
    end
    for (int c = 0; c < 4; c++) bfm(1, 0, r);
    cnt = 0;
    foreach (out_q[i]) begin
      if (out_q[i].tid == 1) begin
        chk($sformatf("t3_beat_%0d", cnt), out_q[i].d, {8'd1, 24'(cnt)});
        chk($sformatf("t3_last_%0d", cnt), out_q[i].last, cnt == 2);
        cnt++;
      end
    end
    chk("t3_nbeats", cnt, 3);

    // Port 0 drops tvalid mid-packet while port 3 waits.
    do_reset(); src_reset();
    en[0] = 1; len[0] = 4; en[3] = 1; len[3] = 1;
    bfm(1, 0, r);
    bfm(1, 0, r);
    en[0] = 0;
    for (int c = 0; c < 3; c++) begin
      bfm(1, 0, r);
      chk("t4_p3_rdy", r[3], 0);
      chk("t4_hold_gidx", gidx, 0);
      chk("t4_hold_gact", gact, 1);
    end
    en[0] = 1;
    for (int c = 0; c < 10 && seq[0] < 4; c++) bfm(1, 0, r);
    chk("t4_p0_done", seq[0], 4);
    bfm(1, 0, r);
    chk("t4_next_gidx", gidx, 3);
    chk("t4_next_gact", gact, 1);
    bfm(1, 0, r);
    chk("t4_p3_rdy_now", r, 4'b1000);

    // Single-beat packets on ports 1 and 3.
    do_reset(); src_reset();
    en[1] = 1; len[1] = 1; en[3] = 1; len[3] = 1;
    out_q.delete();
    for (int c = 0; c < 10; c++) bfm(1, 0, r);
    chk("t5_npkts", out_q.size() >= 4, 1);
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      chk($sformatf("t5_tid_%0d", i), out_q[i].tid, t5_exp[i]);
      chk($sformatf("t5_last_%0d", i), out_q[i].last, 1);
    end

    // Reset during beat 2 of a 4-beat packet on port 2.
    do_reset(); src_reset();
    en[2] = 1; len[2] = 4;
    bfm(1, 0, r);
    bfm(1, 0, r);
    chk("t6_pre_mv", m_tvalid, 1);
    bfm(1, 1, r);
    chk("t6_rst_rdy", r, 0);
    chk("t6_mv", m_tvalid, 0);
    chk("t6_gact", gact, 0);
    chk("t6_gidx", gidx, N - 1);
    en[0] = 1;
    bfm(1, 0, r);
    chk("t6_prio_gidx", gidx, 0);

    // Randomised traffic against the model plus per-port sequence integrity.
    do_reset(); src_reset();
    rand_mode = 1;
    for (int p = 0; p < N; p++) len[p] = $urandom_range(1, 4);
    out_q.delete();
    for (int c = 0; c < 3000; c++) bfm($urandom_range(0, 3) != 0, 0, r);
    for (int p = 0; p < N; p++) es[p] = 0;
    foreach (out_q[i]) begin
      if (out_q[i].tid >= 0 && out_q[i].tid < N) begin
        chk("rand_seq", out_q[i].d, {8'(out_q[i].tid), 24'(es[out_q[i].tid])});
        es[out_q[i].tid]++;
      end
    end
    chk("rand_progress", out_q.size() > 500, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
